// File: rtl/bsg_miniblade_tag_packet_tx_pkg.sv
// Shared helpers for the bsg_tag transmit path: field-width math and the
// on-the-wire packet length, so RTL, benches and trace tools agree.
package bsg_miniblade_tag_packet_tx_pkg;

    // Same result as BSG_SAFE_CLOG2: never returns 0.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Cycles one tag packet occupies on tag_data, including the trailing gap.
    function automatic int tag_packet_bits(input int lg_tag_els, input int tag_lg_width,
                                           input int len, input int gap);
        return 1 + lg_tag_els + 1 + tag_lg_width + len + gap;
    endfunction

endpackage

// File: rtl/bsg_miniblade_tag_field_shifter.sv
// Loadable PISO shift register plus a down-counter whose done flag marks the
// last bit of the field currently being emitted.
module bsg_miniblade_tag_field_shifter #(
    parameter int width_p     = 30,
    parameter int cnt_width_p = 7
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   shift_i,
    input  logic                   cnt_load_i,
    input  logic [cnt_width_p-1:0] cnt_i,
    output logic                   next_bit_o,
    output logic                   done_o
);

    localparam logic [cnt_width_p-1:0] cnt_one_lp = cnt_width_p'(1);

    logic [width_p-1:0]     sr_q, sr_d;
    logic [cnt_width_p-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = sr_q >> 1;
        end
        if (cnt_load_i) begin
            cnt_d = cnt_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - cnt_one_lp;
        end
    end

    // The bit that will sit at the head of the register next cycle.
    assign next_bit_o = sr_d[0];
    assign done_o     = (cnt_q == cnt_one_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bsg_miniblade_tag_packet_tx.sv
// bsg_tag serial transmitter: turns one accepted command (tag packet or
// master-reset preamble) into a registered bit stream on tag_data_o.
module bsg_miniblade_tag_packet_tx
    import bsg_miniblade_tag_packet_tx_pkg::*;
#(
    parameter int tag_els_p      = 1024,
    parameter int tag_lg_width_p = 4,
    parameter int reset_ones_p   = 64,
    parameter int gap_p          = 2
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                v_i,
    output logic                                ready_o,
    input  logic                                is_reset_i,
    input  logic [safe_clog2(tag_els_p)-1:0]    node_id_i,
    input  logic                                data_not_reset_i,
    input  logic [tag_lg_width_p-1:0]           len_i,
    input  logic [(1<<tag_lg_width_p)-2:0]      payload_i,
    output logic                                tag_data_o,
    output logic                                busy_o
);

    localparam int lg_tag_els_lp = safe_clog2(tag_els_p);
    localparam int width_lp      = (1 << tag_lg_width_p) - 1;
    localparam int cnt_max_lp    = max2(max2(reset_ones_p, width_lp), max2(lg_tag_els_lp, gap_p));
    localparam int cnt_width_lp  = safe_clog2(cnt_max_lp + 1);
    localparam int sr_width_lp   = lg_tag_els_lp + 1 + tag_lg_width_p + width_lp;

    localparam logic [cnt_width_lp-1:0] cnt_one_lp = cnt_width_lp'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_START, S_NODE, S_DNR, S_LEN, S_PAYLOAD, S_GAP
    } state_e;

    state_e                       state_q, state_d;
    logic [tag_lg_width_p-1:0]    len_q, len_d;
    logic                         tag_data_q, tag_data_d;
    logic                         load, shift, cnt_load, next_bit, field_done;
    logic [cnt_width_lp-1:0]      cnt_val;

    bsg_miniblade_tag_field_shifter #(
        .width_p     (sr_width_lp),
        .cnt_width_p (cnt_width_lp)
    ) shifter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (load),
        .data_i     ({payload_i, len_i, data_not_reset_i, node_id_i}),
        .shift_i    (shift),
        .cnt_load_i (cnt_load),
        .cnt_i      (cnt_val),
        .next_bit_o (next_bit),
        .done_o     (field_done)
    );

    // State sequencing; the counter is reloaded with the new field length on every state entry.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        load     = 1'b0;
        shift    = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (v_i) begin
                    load     = 1'b1;
                    cnt_load = 1'b1;
                    len_d    = len_i;
                    if (is_reset_i) begin
                        state_d = S_PRE;
                        cnt_val = cnt_width_lp'(reset_ones_p);
                    end else begin
                        state_d = S_START;
                        cnt_val = cnt_one_lp;
                    end
                end
            end
            S_PRE: begin
                if (field_done) begin
                    state_d  = S_GAP;
                    cnt_load = 1'b1;
                    cnt_val  = cnt_width_lp'(gap_p);
                end
            end
            S_START: begin
                if (field_done) begin
                    state_d  = S_NODE;
                    cnt_load = 1'b1;
                    cnt_val  = cnt_width_lp'(lg_tag_els_lp);
                end
            end
            S_NODE: begin
                shift = 1'b1;
                if (field_done) begin
                    state_d  = S_DNR;
                    cnt_load = 1'b1;
                    cnt_val  = cnt_one_lp;
                end
            end
            S_DNR: begin
                shift = 1'b1;
                if (field_done) begin
                    state_d  = S_LEN;
                    cnt_load = 1'b1;
                    cnt_val  = cnt_width_lp'(tag_lg_width_p);
                end
            end
            S_LEN: begin
                shift = 1'b1;
                if (field_done) begin
                    cnt_load = 1'b1;
                    if (len_q != '0) begin
                        state_d = S_PAYLOAD;
                        cnt_val = cnt_width_lp'(len_q);
                    end else begin
                        state_d = S_GAP;
                        cnt_val = cnt_width_lp'(gap_p);
                    end
                end
            end
            S_PAYLOAD: begin
                shift = 1'b1;
                if (field_done) begin
                    state_d  = S_GAP;
                    cnt_load = 1'b1;
                    cnt_val  = cnt_width_lp'(gap_p);
                end
            end
            S_GAP: begin
                if (field_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The output flop carries the bit belonging to the state being entered.
    always_comb begin
        tag_data_d = 1'b0;
        case (state_d)
            S_PRE, S_START:                     tag_data_d = 1'b1;
            S_NODE, S_DNR, S_LEN, S_PAYLOAD:    tag_data_d = next_bit;
            default:                            tag_data_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            tag_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            tag_data_q <= tag_data_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign busy_o     = ~ready_o;
    assign tag_data_o = tag_data_q;

endmodule

// File: tb/tb_bsg_miniblade_tag_packet_tx.sv
// Directed bench for the bsg_tag transmitter with a small behavioural
// tag-master/client decoder watching the serial line.
module tb_bsg_miniblade_tag_packet_tx;
    import bsg_miniblade_tag_packet_tx_pkg::*;

    localparam int TAG_ELS = 1024;
    localparam int LG_W    = 4;
    localparam int RONES   = 64;
    localparam int GAP     = 2;
    localparam int LG_ELS  = safe_clog2(TAG_ELS);
    localparam int WIDTH   = (1 << LG_W) - 1;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              v_i = 1'b0;
    logic              ready_o;
    logic              is_reset_i = 1'b0;
    logic [LG_ELS-1:0] node_id_i = '0;
    logic              dnr_i = 1'b0;
    logic [LG_W-1:0]   len_i = '0;
    logic [WIDTH-1:0]  payload_i = '0;
    logic              tag_data_o;
    logic              busy_o;

    int total = 0;
    int bad   = 0;

    bsg_miniblade_tag_packet_tx #(
        .tag_els_p      (TAG_ELS),
        .tag_lg_width_p (LG_W),
        .reset_ones_p   (RONES),
        .gap_p          (GAP)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .ready_o          (ready_o),
        .is_reset_i       (is_reset_i),
        .node_id_i        (node_id_i),
        .data_not_reset_i (dnr_i),
        .len_i            (len_i),
        .payload_i        (payload_i),
        .tag_data_o       (tag_data_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    // Behavioural receiver: preamble detection plus packet field parsing.
    localparam int D_IDLE = 0, D_NODE = 1, D_DNR = 2, D_LEN = 3, D_PAY = 4, D_RST = 5;
    int               dstate = D_IDLE;
    int               dcnt = 0;
    int               ones = 0;
    logic             oor = 1'b0;
    logic [LG_ELS-1:0] d_node = '0;
    logic             d_dnr = 1'b0;
    logic [LG_W-1:0]  d_len = '0;
    logic [WIDTH-1:0] d_pay = '0;
    logic             client5 = 1'b0;
    logic [LG_ELS-1:0] last_node = '0;
    logic [WIDTH-1:0] last_payload = '0;

    task automatic deliver();
        if (oor) begin
            last_node    = d_node;
            last_payload = d_pay;
            if (d_node == LG_ELS'(5) && d_dnr) client5 = d_pay[0];
        end
        dstate = D_IDLE;
    endtask

    always @(posedge clk) begin
        if (reset_i) begin
            dstate = D_IDLE;
            ones   = 0;
        end else begin
            ones = tag_data_o ? ones + 1 : 0;
            if (ones >= RONES) begin
                dstate = D_RST;
            end else begin
                case (dstate)
                    D_RST:  if (!tag_data_o) begin oor = 1'b1; dstate = D_IDLE; end
                    D_IDLE: if (tag_data_o) begin dstate = D_NODE; dcnt = 0; d_node = '0; end
                    D_NODE: begin
                        d_node[dcnt] = tag_data_o;
                        dcnt++;
                        if (dcnt == LG_ELS) dstate = D_DNR;
                    end
                    D_DNR: begin
                        d_dnr = tag_data_o; dcnt = 0; d_len = '0; dstate = D_LEN;
                    end
                    D_LEN: begin
                        d_len[dcnt] = tag_data_o;
                        dcnt++;
                        if (dcnt == LG_W) begin
                            dcnt = 0;
                            d_pay = '0;
                            if (d_len == '0) deliver();
                            else dstate = D_PAY;
                        end
                    end
                    D_PAY: begin
                        d_pay[dcnt] = tag_data_o;
                        dcnt++;
                        if (dcnt == int'(d_len)) deliver();
                    end
                    default: dstate = D_IDLE;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected wire image, bit i = cycle T+1+i after accept.
    function automatic logic [127:0] build_exp(input logic [LG_ELS-1:0] node, input logic dnr,
                                               input logic [LG_W-1:0] len, input logic [WIDTH-1:0] pay);
        logic [127:0] v;
        int idx;
        v = '0;
        idx = 0;
        v[idx] = 1'b1; idx++;
        for (int k = 0; k < LG_ELS; k++) begin v[idx] = node[k]; idx++; end
        v[idx] = dnr; idx++;
        for (int k = 0; k < LG_W; k++) begin v[idx] = len[k]; idx++; end
        for (int k = 0; k < int'(len); k++) begin v[idx] = pay[k]; idx++; end
        return v;
    endfunction

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send(input logic rst, input logic [LG_ELS-1:0] node, input logic dnr,
                        input logic [LG_W-1:0] len, input logic [WIDTH-1:0] pay, input bit keep_v);
        int w;
        is_reset_i = rst; node_id_i = node; dnr_i = dnr; len_i = len; payload_i = pay;
        v_i = 1'b1;
        w = 0;
        while (!ready_o && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("accept_ready", ready_o, 1'b1);
        $display("tx: rst=%0d node=%0d dnr=%0d len=%0d payload=%0h", rst, node, dnr, len, pay);
        @(posedge clk); #1;
        if (!keep_v) v_i = 1'b0;
    endtask

    task automatic capture(input int n, input int drop_at, output logic [127:0] v, output logic busy_all);
        v = '0;
        busy_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v[i] = tag_data_o;
            busy_all = busy_all & busy_o;
            if (i == drop_at) begin
                @(posedge clk); #1;
                v_i = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] v;
        logic [127:0] e;
        logic [18:0]  hand_n5;
        logic         busy_all;
        logic         acc;
        logic         rdy_all;
        int           la;

        hand_n5 = 19'b0010001100000001011;

        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_tag", tag_data_o, 1'b0);

        acc = 1'b0; rdy_all = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = acc | tag_data_o | busy_o;
            rdy_all = rdy_all & ready_o;
        end
        chk("idle_quiet", acc, 1'b0);
        chk("idle_ready", rdy_all, 1'b1);
        @(posedge clk); #1;

        // Master-reset preamble
        send(1'b1, '0, 1'b0, '0, '0, 1'b0);
        capture(RONES + GAP, -1, v, busy_all);
        chk("pre_bits", v, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        chk("pre_busy", busy_all, 1'b1);
        @(negedge clk);
        chk("pre_ready", ready_o, 1'b1);
        chk("pre_master_out_of_reset", oor, 1'b1);
        @(posedge clk); #1;

        // node 5, dnr 1, len 1, payload 1
        send(1'b0, LG_ELS'(5), 1'b1, LG_W'(1), WIDTH'(1), 1'b0);
        capture(19, -1, v, busy_all);
        chk("n5_bits", v, {109'b0, hand_n5});
        @(negedge clk);
        chk("n5_ready", ready_o, 1'b1);
        chk("n5_client", client5, 1'b1);
        @(posedge clk); #1;

        // len 0: payload bits must be ignored
        send(1'b0, LG_ELS'(3), 1'b1, LG_W'(0), 15'h7FFF, 1'b0);
        capture(tag_packet_bits(LG_ELS, LG_W, 0, GAP) + 2, -1, v, busy_all);
        chk("len0_bits", v, build_exp(LG_ELS'(3), 1'b1, LG_W'(0), '0));
        chk("len0_client", {last_node, last_payload}, {LG_ELS'(3), WIDTH'(0)});
        @(posedge clk); #1;

        // len 15, full payload
        send(1'b0, LG_ELS'(9), 1'b1, LG_W'(15), 15'h5A5A, 1'b0);
        capture(tag_packet_bits(LG_ELS, LG_W, 15, GAP), -1, v, busy_all);
        chk("len15_bits", v, build_exp(LG_ELS'(9), 1'b1, LG_W'(15), 15'h5A5A));
        @(negedge clk);
        chk("len15_ready", ready_o, 1'b1);
        chk("len15_client", last_payload, 15'h5A5A);
        @(posedge clk); #1;

        // Back-to-back with fields changed right after the first accept
        la = tag_packet_bits(LG_ELS, LG_W, 2, GAP);
        send(1'b0, LG_ELS'(3), 1'b1, LG_W'(2), WIDTH'(2), 1'b1);
        node_id_i = LG_ELS'(9); dnr_i = 1'b0; len_i = LG_W'(3); payload_i = WIDTH'(5);
        capture(la + 1 + tag_packet_bits(LG_ELS, LG_W, 3, GAP), la, v, busy_all);
        e = build_exp(LG_ELS'(3), 1'b1, LG_W'(2), WIDTH'(2)) |
            (build_exp(LG_ELS'(9), 1'b0, LG_W'(3), WIDTH'(5)) << (la + 1));
        chk("b2b_bits", v, e);
        @(negedge clk);
        chk("b2b_ready", ready_o, 1'b1);
        chk("b2b_client", {last_node, last_payload}, {LG_ELS'(9), WIDTH'(5)});
        @(posedge clk); #1;

        // Abort at the 7th NODE bit
        send(1'b0, LG_ELS'(5), 1'b1, LG_W'(1), WIDTH'(0), 1'b0);
        capture(7, -1, v, busy_all);
        e = build_exp(LG_ELS'(5), 1'b1, LG_W'(1), WIDTH'(0));
        chk("abort_prefix", v[6:0], e[6:0]);
        @(posedge clk); #1 reset_i = 1'b1;
        @(negedge clk);
        chk("abort_node_bit7", tag_data_o, e[7]);
        @(posedge clk); #1 reset_i = 1'b0;
        @(negedge clk);
        chk("abort_tag", tag_data_o, 1'b0);
        chk("abort_ready", ready_o, 1'b1);
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc = acc | tag_data_o;
        end
        chk("abort_quiet", acc, 1'b0);
        chk("abort_client_kept", client5, 1'b1);
        @(posedge clk); #1;

        send(1'b0, LG_ELS'(5), 1'b1, LG_W'(1), WIDTH'(0), 1'b0);
        capture(19, -1, v, busy_all);
        chk("post_abort_bits", v, build_exp(LG_ELS'(5), 1'b1, LG_W'(1), WIDTH'(0)));
        @(negedge clk);
        chk("post_abort_ready", ready_o, 1'b1);
        chk("post_abort_client", client5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_miniblade_tag_packet_tx.md
Name: bsg_miniblade_tag_packet_tx

Overview:
- Transmit side of the bsg_tag serial protocol.
- Accepts one command per valid/ready handshake. Each command is either a tag packet (node id, data_not_reset, length, payload) or a master-reset preamble.
- Serializes the command onto the single-bit tag_data line consumed by bsg_tag_master_decentralized instances, such as the tile I/O router corners.
- Sits in the tag clock domain on the host/bringup side of the miniblade and drives the tag_clk/tag_data pair chained to all tiles.

Parameters:
- tag_els_p, 1024: number of tag clients addressable; node id width lg_tag_els_lp = `BSG_SAFE_CLOG2(tag_els_p)`.
- tag_lg_width_p, 4: width of the length field; max payload width_lp = (1<<tag_lg_width_p)-1.
- reset_ones_p, 64: number of consecutive '1' bits in the master-reset preamble.
- gap_p, 2: number of idle '0' bits forced after every packet or preamble; must be >= 1.

Ports:
- clk_i  input  1  tag clock; all state on posedge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  1  command valid.
- ready_o  output  1  command accepted when v_i & ready_o.
- is_reset_i  input  1  1 = send master-reset preamble; the remaining fields are ignored.
- node_id_i  input  lg_tag_els_lp  destination client id.
- data_not_reset_i  input  1  0 = client reset packet, 1 = data packet.
- len_i  input  tag_lg_width_p  payload bit count, 0..width_lp.
- payload_i  input  width_lp  payload, LSB sent first; bits >= len_i are ignored.
- tag_data_o  output  1  serial bit stream, registered.
- busy_o  output  1  high while any bit of a command (including gap) is pending.

Behaviour:
- Reset: state IDLE, tag_data_o=0, busy_o=0, ready_o=1 in the first cycle after reset deasserts. reset_i mid-packet aborts immediately: tag_data_o=0 the next cycle and the command is discarded.
- ready_o = (state==IDLE). busy_o = ~ready_o. On accept, all fields are latched into internal registers; inputs may change afterward.
- Latency: accept in cycle T; the first serialized bit appears on tag_data_o in cycle T+1. One bit per cycle, with no bubbles until the gap completes.
- FSM states: IDLE, PRE, START, NODE, DNR, LEN, PAYLOAD, GAP.
- IDLE: tag_data_o=0. Accept with is_reset_i=1 goes to PRE; accept with is_reset_i=0 goes to START.
- PRE: emit '1' for reset_ones_p cycles, then go to GAP.
- START: emit '1' for 1 cycle, then go to NODE.
- NODE: emit node_id LSB-first over lg_tag_els_lp cycles, then go to DNR.
- DNR: emit data_not_reset for 1 cycle, then go to LEN.
- LEN: emit len LSB-first over tag_lg_width_p cycles. Next state is PAYLOAD if len!=0, else GAP.
- PAYLOAD: emit payload[0..len-1] LSB-first, then go to GAP.
- GAP: emit '0' for gap_p cycles, then go to IDLE.
- Packet length on the wire = 1 + lg_tag_els_lp + 1 + tag_lg_width_p + len + gap_p cycles. ready_o reasserts the cycle after the last gap bit.
- Counter: one down-counter, width `BSG_SAFE_CLOG2(max(reset_ones_p, width_lp, lg_tag_els_lp, gap_p)+1)`, reloaded on each state entry.
- Shift register: width lg_tag_els_lp + 1 + tag_lg_width_p + width_lp. Loaded on accept, shifted right one bit per emitted field bit.
- len_i=0: no PAYLOAD cycles; LEN goes directly to GAP.
- len_i=width_lp: all payload bits are sent.
- Back-to-back commands: a new command may be accepted in the IDLE cycle. The minimum inter-start spacing is therefore the packet length + 1.
- v_i held low: the output stays 0 indefinitely. A '1' never appears except in PRE, START, or a field bit.

Decomposition:
- Field-width localparams (lg_tag_els_lp, width_lp) are derived with the same formulas as bsg_tag_pkg/bsg_tag_master. Add to bsg_tag_pkg a shared function returning the packet bit length for a given len, so testbenches and trace tools agree.
- FSM state enum is local to the module.
- Sub-module: bsg_miniblade_tag_field_shifter, a loadable PISO shift register plus down-counter with a done flag, reused per field.

Test Plan:
- Reset, then idle 20 cycles -> tag_data_o=0 throughout, ready_o=1, busy_o=0.
- is_reset_i=1, reset_ones_p=64, gap_p=2, accept at T -> tag_data_o=1 for T+1..T+64, 0 for T+65..T+66, ready_o=1 at T+67. A bsg_tag_master_decentralized in the bench exits reset.
- Packet node=5, dnr=1, len=1, payload=1, 10-bit node id, 4-bit len, accept at T -> bits T+1..T+17 = 1, 1010000000, 1, 1000, 1, then 0,0. ready_o high at T+20. The bench's bsg_tag_client(width_p=1, node 5) shows recv_data_r_o=1.
- len=0 packet -> no payload bits, 16 field bits + gap. len=15, payload=16'h5A5A&15'h7FFF -> 15 payload bits, LSB-first, matching the bench client's value.
- Two commands with v_i held high, fields changed immediately after accept -> the second packet starts exactly 1 idle cycle after the first gap, and the first packet's bits are unaffected by the input change.
- reset_i asserted at the 7th NODE bit -> tag_data_o=0 from the next cycle, ready_o=1 after reset, and a following packet is sent correctly. The downstream client value is unchanged by the aborted packet.
